// File: rtl/motor_cmd_ctrl_pkg.sv
// motor_cmd_ctrl_pkg: command and state encodings shared with the Motor block
// Exports CMD_* bus codes, ST_* state codes and cmd_of(), the state-to-command decode.
package motor_cmd_ctrl_pkg;
    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_UP    = 3'd1;
    localparam logic [2:0] ST_DOWN  = 3'd2;
    localparam logic [2:0] ST_DWELL = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;
    function automatic logic [1:0] cmd_of(input logic [2:0] st);
        return st == ST_UP ? CMD_UP : st == ST_DOWN ? CMD_DOWN : CMD_STOP;
    endfunction
endpackage

// File: rtl/motor_cmd_ctrl_btn_sync.sv
// motor_cmd_ctrl_btn_sync: 2-FF synchroniser plus rising-edge detect for one raw button
// Ports: clk, reset (async active-low), btn_in (raw, async), pulse_out (1-cycle pulse per press)
module motor_cmd_ctrl_btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_out
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], btn_in};
    end
    // sync_q[1] is the synchronised level, sync_q[2] its previous value
    assign pulse_out = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/motor_cmd_ctrl.sv
// motor_cmd_ctrl: turns up/down/stop buttons into the Motor cmd bus with limits, reversal dwell and fault latch
// Ports: clk, reset (async active-low), btn_up/btn_down/btn_stop (raw), tope_a_s/tope_b_s (top/bottom limit),
//        cmd (00 stop, 01 up, 10 down), state_o (FSM state), fault (high in FAULT)
module motor_cmd_ctrl import motor_cmd_ctrl_pkg::*; #(
    parameter int MAX_TRAVEL  = 500_000_000,
    parameter int DEAD_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_stop,
    input  logic       tope_a_s,
    input  logic       tope_b_s,
    output logic [1:0] cmd,
    output logic [2:0] state_o,
    output logic       fault
);
    localparam int TW = $clog2(MAX_TRAVEL + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    logic          up_p, dn_p, st_p;
    logic          stop_req, up_req, dn_req, travel_done, dwell_done;
    logic [2:0]    state_q, state_d;
    logic [1:0]    pending_q, pending_d, cmd_q;
    logic [TW-1:0] travel_q, travel_d;
    logic [DW-1:0] dwell_q, dwell_d;
    motor_cmd_ctrl_btn_sync u_sync_up   (.clk(clk), .reset(reset), .btn_in(btn_up),   .pulse_out(up_p));
    motor_cmd_ctrl_btn_sync u_sync_down (.clk(clk), .reset(reset), .btn_in(btn_down), .pulse_out(dn_p));
    motor_cmd_ctrl_btn_sync u_sync_stop (.clk(clk), .reset(reset), .btn_in(btn_stop), .pulse_out(st_p));
    // simultaneous up and down is an ambiguous request, so it acts as stop
    assign stop_req    = st_p | (up_p & dn_p);
    assign up_req      = up_p & ~dn_p;
    assign dn_req      = dn_p & ~up_p;
    assign travel_done = travel_q == TW'(MAX_TRAVEL - 1);
    assign dwell_done  = dwell_q == DW'(DEAD_CYCLES - 1);
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (tope_a_s && tope_b_s) state_d = ST_FAULT;
        else if (stop_req) begin
            state_d   = ST_IDLE;
            pending_d = CMD_STOP;
        end else begin
            case (state_q)
                ST_IDLE: state_d = (up_req && !tope_a_s) ? ST_UP : (dn_req && !tope_b_s) ? ST_DOWN : ST_IDLE;
                ST_UP: begin
                    if (tope_a_s) state_d = ST_IDLE;
                    else if (travel_done) state_d = ST_FAULT;
                    else if (dn_req) begin
                        state_d   = ST_DWELL;
                        pending_d = CMD_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (tope_b_s) state_d = ST_IDLE;
                    else if (travel_done) state_d = ST_FAULT;
                    else if (up_req) begin
                        state_d   = ST_DWELL;
                        pending_d = CMD_UP;
                    end
                end
                ST_DWELL: begin
                    // dwell expiry outranks a request arriving on the same cycle
                    if (dwell_done) begin
                        state_d   = pending_q == CMD_UP ? (tope_a_s ? ST_IDLE : ST_UP)
                                                        : (tope_b_s ? ST_IDLE : ST_DOWN);
                        pending_d = CMD_STOP;
                    end else if (up_req) pending_d = CMD_UP;
                    else if (dn_req) pending_d = CMD_DOWN;
                end
                default: ;
            endcase
        end
    end
    // both counters restart on any state change, so each entry into UP/DOWN/DWELL starts at zero
    assign travel_d = state_d != state_q ? '0 : travel_q == TW'(MAX_TRAVEL) ? travel_q : travel_q + TW'(1);
    assign dwell_d  = state_d != state_q ? '0 : dwell_q == DW'(DEAD_CYCLES) ? dwell_q : dwell_q + DW'(1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= CMD_STOP;
            travel_q  <= '0;
            dwell_q   <= '0;
            cmd_q     <= CMD_STOP;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            travel_q  <= travel_d;
            dwell_q   <= dwell_d;
            cmd_q     <= cmd_of(state_d);
        end
    end
    assign cmd     = cmd_q;
    assign state_o = state_q;
    assign fault   = state_q == ST_FAULT;
endmodule

// File: tb/tb_motor_cmd_ctrl.sv
// tb_motor_cmd_ctrl: directed and randomized bench for motor_cmd_ctrl against an edge-time reference model
module tb_motor_cmd_ctrl;
    localparam int MAXT = 100;
    localparam int DEAD = 8;
    logic       clk = 1'b0;
    logic       reset, btn_up, btn_down, btn_stop, tope_a_s, tope_b_s;
    logic [1:0] cmd;
    logic [2:0] state_o;
    logic       fault;
    int         n_checks = 0;
    int         n_errors = 0;
    // model: state 0 idle,1 up,2 down,3 dwell,4 fault; time measured in edges since state entry
    int         m_st, m_pend, m_entry, m_edge;
    logic [2:0] hu, hd, hs;
    always #5 clk = ~clk;
    motor_cmd_ctrl #(.MAX_TRAVEL(MAXT), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_stop(btn_stop),
        .tope_a_s(tope_a_s), .tope_b_s(tope_b_s), .cmd(cmd), .state_o(state_o), .fault(fault)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int exp_cmd();
        return m_st == 1 ? 1 : m_st == 2 ? 2 : 0;
    endfunction
    task automatic model_reset();
        m_st = 0; m_pend = 0; m_entry = 0;
        hu = '0; hd = '0; hs = '0;
    endtask
    // a press sampled at edge n-2 after a low sample at n-3 acts at edge n
    task automatic model_step();
        logic pu, pd, ps, stp, ur, dr;
        int   ns, held;
        pu = hu[1] & ~hu[2]; pd = hd[1] & ~hd[2]; ps = hs[1] & ~hs[2];
        hu = {hu[1:0], btn_up}; hd = {hd[1:0], btn_down}; hs = {hs[1:0], btn_stop};
        stp  = ps | (pu & pd);
        ur   = pu & ~pd;
        dr   = pd & ~pu;
        held = m_edge - m_entry;
        ns   = m_st;
        if (tope_a_s && tope_b_s) ns = 4;
        else if (stp) begin ns = 0; m_pend = 0; end
        else if (m_st == 0) begin
            if (ur && !tope_a_s) ns = 1;
            else if (dr && !tope_b_s) ns = 2;
        end else if (m_st == 1 || m_st == 2) begin
            if (m_st == 1 ? tope_a_s : tope_b_s) ns = 0;
            else if (held == MAXT) ns = 4;
            else if (m_st == 1 ? dr : ur) begin ns = 3; m_pend = 3 - m_st; end
        end else if (m_st == 3) begin
            if (held == DEAD) ns = (m_pend == 1 ? tope_a_s : tope_b_s) ? 0 : m_pend;
            else if (ur) m_pend = 1;
            else if (dr) m_pend = 2;
        end
        if (ns != m_st) m_entry = m_edge;
        m_st = ns;
        m_edge++;
    endtask
    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        chk("cmd", 32'(cmd), exp_cmd());
        chk("state", 32'(state_o), m_st);
        chk("fault", 32'(fault), m_st == 4 ? 1 : 0);
    endtask
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic press(input logic u, input logic d, input logic s);
        btn_up = u; btn_down = d; btn_stop = s;
        tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0;
        tick();
        tick();
    endtask
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_fault", 32'(fault), 0);
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask
    task automatic count_run(input logic [1:0] v, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cmd === v && n < 1000);
    endtask
    initial begin
        int         n, entries;
        logic [2:0] prev;
        reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0; tope_a_s = 1'b0; tope_b_s = 1'b0;
        model_reset();
        m_edge = 0;
        cycles(2);
        reset = 1'b1;
        cycles(3);
        press(1, 0, 0);
        chk("up_latency", 32'(cmd), 1);
        cycles(4);
        do_reset();
        cycles(2);
        press(1, 0, 0);
        chk("t2_up", 32'(cmd), 1);
        cycles(36);
        tope_a_s = 1'b1;
        tick();
        chk("t2_lim_cmd", 32'(cmd), 0);
        chk("t2_lim_state", 32'(state_o), 0);
        tope_a_s = 1'b0;
        cycles(2);
        press(1, 0, 0);
        cycles(5);
        press(0, 1, 0);
        chk("t3_dwell_cmd", 32'(cmd), 0);
        count_run(2'b00, n);
        chk("t3_dwell_len", n, DEAD);
        chk("t3_reversed", 32'(cmd), 2);
        press(0, 0, 1);
        press(1, 0, 0);
        cycles(5);
        press(0, 1, 0);
        tope_b_s = 1'b1;
        cycles(12);
        chk("t3_lim_state", 32'(state_o), 0);
        chk("t3_lim_cmd", 32'(cmd), 0);
        tope_b_s = 1'b0;
        cycles(2);
        press(1, 0, 0);
        count_run(2'b01, n);
        chk("t4_run_len", n, MAXT);
        chk("t4_fault", 32'(fault), 1);
        chk("t4_state", 32'(state_o), 4);
        press(1, 0, 0);
        cycles(3);
        chk("t4_up_ignored", 32'(state_o), 4);
        press(0, 0, 1);
        chk("t4_cleared", 32'(state_o), 0);
        chk("t4_fault_low", 32'(fault), 0);
        tope_a_s = 1'b1;
        press(1, 0, 0);
        cycles(3);
        chk("t5_at_limit", 32'(cmd), 0);
        tope_a_s = 1'b0;
        press(0, 1, 0);
        chk("t5_down", 32'(cmd), 2);
        cycles(3);
        tope_a_s = 1'b1; tope_b_s = 1'b1;
        tick();
        chk("t5_lim_err", 32'(state_o), 4);
        tope_a_s = 1'b0; tope_b_s = 1'b0;
        press(0, 0, 1);
        chk("t5_exit", 32'(state_o), 0);
        press(1, 1, 0);
        cycles(3);
        chk("t6_both", 32'(state_o), 0);
        btn_up = 1'b1;
        entries = 0;
        prev = state_o;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (state_o == 3'd1 && prev != 3'd1) entries++;
            prev = state_o;
        end
        btn_up = 1'b0;
        chk("t6_entries", entries, 1);
        press(0, 0, 1);
        press(1, 0, 0);
        cycles(5);
        press(0, 1, 0);
        cycles(2);
        press(0, 0, 1);
        cycles(20);
        chk("t6_no_rev_st", 32'(state_o), 0);
        chk("t6_no_rev_cmd", 32'(cmd), 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 29) == 0) btn_stop = ~btn_stop;
            if ($urandom_range(0, 49) == 0) tope_a_s = ~tope_a_s;
            if ($urandom_range(0, 49) == 0) tope_b_s = ~tope_b_s;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
